// File: rtl/ntsc_pkg.sv
// Constants and types shared by the NTSC DAC output stage and the composite
// sample generator upstream of it.
package ntsc_pkg;

  localparam int IN_W    = 12;
  localparam int OUT_W   = 8;
  localparam int GAIN_FB = 7;
  localparam int GAIN_W  = 9;
  localparam int OFFS_W  = 10;
  localparam int FW      = IN_W - OUT_W;

  typedef enum logic [1:0] {
    MODE_TRUNC = 2'd0,
    MODE_ROUND = 2'd1,
    MODE_EF1   = 2'd2,
    MODE_EF2   = 2'd3
  } mode_e;

  localparam logic [IN_W-1:0] SYNC  = 12'h000;
  localparam logic [IN_W-1:0] BLACK = 12'h4CD;
  localparam logic [IN_W-1:0] WHITE = 12'hFFF;

  function automatic logic is_ef(input mode_e m);
    return (m == MODE_EF1) || (m == MODE_EF2);
  endfunction

endpackage

// File: rtl/ntsc_dac_shaper_if.sv
// Sample stream, trim configuration and DAC output bundle between the
// generator side (master) and the DAC shaper (slave).
interface ntsc_dac_shaper_if;
  import ntsc_pkg::*;

  logic [IN_W-1:0]          sample_i;
  logic                     sample_valid_i;
  logic                     cfg_invert_i;
  logic [GAIN_W-1:0]        cfg_gain_i;
  logic signed [OFFS_W-1:0] cfg_offset_i;
  logic [1:0]               cfg_mode_i;
  logic                     clip_clear_i;
  logic [OUT_W-1:0]         dac_o;
  logic                     dac_valid_o;
  logic                     clip_o;

  modport master (
    output sample_i, sample_valid_i, cfg_invert_i, cfg_gain_i,
           cfg_offset_i, cfg_mode_i, clip_clear_i,
    input  dac_o, dac_valid_o, clip_o
  );

  modport slave (
    input  sample_i, sample_valid_i, cfg_invert_i, cfg_gain_i,
           cfg_offset_i, cfg_mode_i, clip_clear_i,
    output dac_o, dac_valid_o, clip_o
  );

endinterface

// File: rtl/ntsc_noise_shaper.sv
// Final requantization stage: truncate, round, or 1st/2nd-order error-feedback
// shaping down to the DAC pin width, with the feedback state cleared on mode change.
module ntsc_noise_shaper
  import ntsc_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_override_n,
  input  logic [IN_W-1:0]  y,
  input  logic             vld,
  input  mode_e            mode,
  output logic [OUT_W-1:0] dac,
  output logic             dac_valid
);

  localparam int V_W = IN_W + 3;
  localparam logic signed [V_W-1:0] V_MAX = V_W'((1 << IN_W) - 1);
  localparam logic [IN_W:0] HALF = (IN_W+1)'(1) << (FW - 1);

  function automatic logic [IN_W-1:0] clamp_v(input logic signed [V_W-1:0] v);
    if (v < 0)          return '0;
    else if (v > V_MAX) return '1;
    else                return v[IN_W-1:0];
  endfunction

  function automatic logic [OUT_W-1:0] round_sat(input logic [IN_W-1:0] s);
    logic [IN_W:0] r;
    r = {1'b0, s} + HALF;
    return r[IN_W] ? '1 : r[IN_W-1:FW];
  endfunction

  mode_e            mode_q;
  logic [FW-1:0]    e1, e2;
  logic             mode_chg;
  logic [FW-1:0]    e1_use, e2_use;
  logic signed [V_W-1:0] v;
  logic [IN_W-1:0]  vc;
  logic [FW-1:0]    e_new;
  logic [OUT_W-1:0] q;

  // A newly seen mode must not inherit feedback built up under the old one.
  assign mode_chg = (mode != mode_q);
  assign e1_use   = mode_chg ? '0 : e1;
  assign e2_use   = mode_chg ? '0 : e2;

  always_comb begin
    v = $signed({3'b000, y}) + $signed({{(V_W-FW){1'b0}}, e1_use});
    if (mode == MODE_EF2)
      v = $signed({3'b000, y}) + $signed({{(V_W-FW-1){1'b0}}, e1_use, 1'b0})
          - $signed({{(V_W-FW){1'b0}}, e2_use});
    vc    = clamp_v(v);
    e_new = vc[FW-1:0];
    case (mode)
      MODE_TRUNC: q = y[IN_W-1:FW];
      MODE_ROUND: q = round_sat(y);
      default:    q = vc[IN_W-1:FW];
    endcase
  end

  // ---- S3 register: DAC code and error-feedback state ----
  always_ff @(posedge clk_i or negedge rst_override_n) begin
    if (!rst_override_n) begin
      mode_q    <= MODE_TRUNC;
      dac       <= '0;
      dac_valid <= 1'b0;
      e1        <= '0;
      e2        <= '0;
    end else begin
      mode_q    <= mode;
      dac_valid <= vld;
      if (vld) dac <= q;
      if (!is_ef(mode)) begin
        e1 <= '0;
        e2 <= '0;
      end else if (vld) begin
        e2 <= e1_use;
        e1 <= e_new;
      end else if (mode_chg) begin
        e1 <= '0;
        e2 <= '0;
      end
    end
  end

endmodule

// File: rtl/ntsc_dac_shaper.sv
// NTSC composite output stage: invert, gain/offset trim with saturation and a
// sticky clip flag, then requantization to the R-2R DAC pins.
module ntsc_dac_shaper
  import ntsc_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_override_n,
  ntsc_dac_shaper_if.slave bus
);

  localparam int PROD_W = IN_W + GAIN_W;
  // Two bits above the scaled product so gain 511 plus a full positive
  // offset cannot wrap into a negative trimmed value.
  localparam int Y_W = PROD_W - GAIN_FB + 2;
  localparam logic signed [Y_W-1:0] Y_MAX = Y_W'((1 << IN_W) - 1);

  function automatic logic [IN_W-1:0] clamp_y(input logic signed [Y_W-1:0] v);
    if (v < 0)          return '0;
    else if (v > Y_MAX) return '1;
    else                return v[IN_W-1:0];
  endfunction

  logic [IN_W-1:0]        x_p0;
  logic                   vld_p0;
  logic [PROD_W-1:0]      prod;
  logic signed [Y_W-1:0]  y_raw;
  logic                   clamp_hit;
  logic [IN_W-1:0]        y_p1;
  logic                   vld_p1;
  logic                   clip_q;
  logic [OUT_W-1:0]       dac;
  logic                   dac_valid;

  // ---- S1 register: input capture with optional inversion ----
  always_ff @(posedge clk_i or negedge rst_override_n) begin
    if (!rst_override_n) begin
      x_p0   <= '0;
      vld_p0 <= 1'b0;
    end else begin
      x_p0   <= bus.cfg_invert_i ? ~bus.sample_i : bus.sample_i;
      vld_p0 <= bus.sample_valid_i;
    end
  end

  assign prod      = PROD_W'(x_p0) * PROD_W'(bus.cfg_gain_i);
  assign y_raw     = $signed({2'b00, prod[PROD_W-1:GAIN_FB]}) + Y_W'(bus.cfg_offset_i);
  assign clamp_hit = vld_p0 && ((y_raw < 0) || (y_raw > Y_MAX));

  // ---- S2 register: trimmed, saturated sample and clip flag ----
  always_ff @(posedge clk_i or negedge rst_override_n) begin
    if (!rst_override_n) begin
      y_p1   <= '0;
      vld_p1 <= 1'b0;
      clip_q <= 1'b0;
    end else begin
      y_p1   <= clamp_y(y_raw);
      vld_p1 <= vld_p0;
      if (clamp_hit)             clip_q <= 1'b1;
      else if (bus.clip_clear_i) clip_q <= 1'b0;
    end
  end

  ntsc_noise_shaper u_shaper (
    .clk_i          (clk_i),
    .rst_override_n (rst_override_n),
    .y              (y_p1),
    .vld            (vld_p1),
    .mode           (mode_e'(bus.cfg_mode_i)),
    .dac            (dac),
    .dac_valid      (dac_valid)
  );

  assign bus.dac_o       = dac;
  assign bus.dac_valid_o = dac_valid;
  assign bus.clip_o      = clip_q;

endmodule

// File: tb/tb_ntsc_dac_shaper.sv
// Scoreboard bench for ntsc_dac_shaper: a behavioural model queues the expected
// code for each valid sample; a negedge monitor pops and compares.
module tb_ntsc_dac_shaper;
  import ntsc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #35 clk = ~clk;

  ntsc_dac_shaper_if bus();

  ntsc_dac_shaper dut (
    .clk_i          (clk),
    .rst_override_n (rst_n),
    .bus            (bus)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  int   sb[$];
  int   m_e1 = 0;
  int   m_e2 = 0;
  logic [2:0] vh;
  bit   sum_on = 1'b0;
  int   sum_acc = 0;
  int   sum_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model of the whole datapath for one valid sample.
  function automatic int model(input int x);
    int xi, y, v, q, en;
    xi = bus.cfg_invert_i ? 4095 - x : x;
    y  = (xi * int'(bus.cfg_gain_i)) / 128 + int'(bus.cfg_offset_i);
    if (y < 0) y = 0;
    else if (y > 4095) y = 4095;
    case (int'(bus.cfg_mode_i))
      0: q = y / 16;
      1: begin
        q = (y + 8) / 16;
        if (q > 255) q = 255;
      end
      default: begin
        v = (bus.cfg_mode_i == 2'd3) ? y + 2 * m_e1 - m_e2 : y + m_e1;
        if (v < 0) v = 0;
        else if (v > 4095) v = 4095;
        q  = v / 16;
        en = v - q * 16;
        m_e2 = m_e1;
        m_e1 = en;
      end
    endcase
    return q;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) vh <= 3'b000;
    else        vh <= {vh[1:0], bus.sample_valid_i};

  always @(negedge clk) begin
    if (rst_n) begin
      chk("dac_valid", {31'd0, bus.dac_valid_o}, {31'd0, vh[2]});
      if (bus.dac_valid_o) begin
        int exp;
        exp = (sb.size() != 0) ? sb.pop_front() : -1;
        chk("dac_o", {24'd0, bus.dac_o}, exp);
        if (sum_on) begin
          sum_acc += int'(bus.dac_o);
          sum_cnt++;
        end
      end
    end
  end

  task automatic drive(input logic [IN_W-1:0] x, input bit v);
    @(posedge clk);
    #1;
    bus.sample_i       = x;
    bus.sample_valid_i = v;
    if (v) sb.push_back(model(int'(x)));
  endtask

  task automatic idle(input int n);
    repeat (n) drive('0, 1'b0);
  endtask

  task automatic set_cfg(input bit inv, input int gain, input int off, input int mode);
    idle(4);
    if (mode != int'(bus.cfg_mode_i) || mode < 2) begin
      m_e1 = 0;
      m_e2 = 0;
    end
    bus.cfg_invert_i = inv;
    bus.cfg_gain_i   = GAIN_W'(gain);
    bus.cfg_offset_i = OFFS_W'(off);
    bus.cfg_mode_i   = 2'(mode);
  endtask

  initial begin
    #(70 * 20000);
    $display("FAIL watchdog: run did not complete, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    bus.sample_i       = '0;
    bus.sample_valid_i = 1'b0;
    bus.cfg_invert_i   = 1'b0;
    bus.cfg_gain_i     = 9'd128;
    bus.cfg_offset_i   = '0;
    bus.cfg_mode_i     = 2'd0;
    bus.clip_clear_i   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_dac", {24'd0, bus.dac_o}, 32'd0);
    chk("rst_valid", {31'd0, bus.dac_valid_o}, 32'd0);
    chk("rst_clip", {31'd0, bus.clip_o}, 32'd0);
    @(posedge clk);
    #10 rst_n = 1'b1;

    // Unity trim, truncation: black level
    set_cfg(1'b0, 128, 0, 0);
    drive(BLACK, 1'b1);
    idle(4);
    chk("t1_clip", {31'd0, bus.clip_o}, 32'd0);

    // Rounding, including saturation at white
    set_cfg(1'b0, 128, 0, 1);
    drive(WHITE, 1'b1);
    drive(12'h4C8, 1'b1);
    drive(12'h7F7, 1'b1);
    set_cfg(1'b1, 128, 0, 1);
    drive(12'h100, 1'b1);
    drive(SYNC, 1'b1);
    set_cfg(1'b0, 128, 37, 0);
    drive(12'h400, 1'b1);
    set_cfg(1'b0, 200, -100, 1);
    drive(12'h555, 1'b1);
    idle(4);
    chk("t2_clip", {31'd0, bus.clip_o}, 32'd0);

    // Over-range gain: clamp, sticky flag, set beats clear
    set_cfg(1'b0, 256, 0, 0);
    drive(12'h900, 1'b1);
    idle(4);
    chk("clip_set", {31'd0, bus.clip_o}, 32'd1);
    bus.clip_clear_i = 1'b1;
    idle(1);
    bus.clip_clear_i = 1'b0;
    idle(1);
    chk("clip_clear", {31'd0, bus.clip_o}, 32'd0);
    drive(12'h900, 1'b1);
    drive('0, 1'b0);
    bus.clip_clear_i = 1'b1;
    drive('0, 1'b0);
    bus.clip_clear_i = 1'b0;
    idle(3);
    chk("clip_set_wins", {31'd0, bus.clip_o}, 32'd1);
    bus.clip_clear_i = 1'b1;
    idle(1);
    bus.clip_clear_i = 1'b0;
    idle(1);
    chk("clip_clear2", {31'd0, bus.clip_o}, 32'd0);

    // Negative offset clamps at zero
    set_cfg(1'b0, 128, -512, 0);
    drive(12'h100, 1'b1);
    idle(4);
    chk("clip_low", {31'd0, bus.clip_o}, 32'd1);
    bus.clip_clear_i = 1'b1;
    idle(1);
    bus.clip_clear_i = 1'b0;

    // First-order shaping: 0x80.8 alternates 0x80/0x81
    set_cfg(1'b0, 128, 0, 2);
    repeat (8) drive(12'h808, 1'b1);

    // Second-order shaping: long-run mean 0x80.4
    set_cfg(1'b0, 128, 0, 3);
    sum_acc = 0;
    sum_cnt = 0;
    sum_on  = 1'b1;
    repeat (64) drive(12'h804, 1'b1);
    idle(4);
    sum_on = 1'b0;
    chk("ef2_count", sum_cnt, 32'd64);
    chk("ef2_mean_in_band", {31'd0, (sum_acc >= 8144 && sum_acc <= 8272)}, 32'd1);

    // Valid gaps in EF1: bubbles leave the error state alone
    set_cfg(1'b0, 128, 0, 2);
    repeat (8) begin
      drive(12'h808, 1'b1);
      drive(12'h808, 1'b0);
    end

    // Asynchronous reset mid-stream in EF1
    set_cfg(1'b0, 128, 0, 2);
    repeat (6) drive(12'h80B, 1'b1);
    @(posedge clk);
    #20;
    chk("pre_rst_dac_nz", {31'd0, bus.dac_o != 0}, 32'd1);
    rst_n = 1'b0;
    bus.sample_valid_i = 1'b0;
    #1;
    chk("async_rst_dac", {24'd0, bus.dac_o}, 32'd0);
    chk("async_rst_valid", {31'd0, bus.dac_valid_o}, 32'd0);
    sb.delete();
    m_e1 = 0;
    m_e2 = 0;
    repeat (2) @(posedge clk);
    #15 rst_n = 1'b1;
    drive(BLACK, 1'b1);
    drive(BLACK, 1'b1);
    idle(5);
    chk("post_rst_clip", {31'd0, bus.clip_o}, 32'd0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
